// File: rtl/drp_adc_responder.sv
// XADC-style DRP responder: per-channel result registers filled by a round-robin
// conversion sequencer, served to a DRP initiator with a fixed read/write latency.
module drp_adc_responder #(
  parameter int         NUM_CH     = 13,
  parameter logic [6:0] BASE_ADDR  = 7'h10,
  parameter int         EOC_PERIOD = 26,
  parameter int         RD_LATENCY = 4
) (
  input  logic        dclk,
  input  logic        rst_n,
  input  logic        den_in,
  input  logic        dwe_in,
  input  logic [6:0]  daddr_in,
  input  logic [15:0] di_in,
  output logic [15:0] do_out,
  output logic        drdy_out,
  output logic [3:0]  samp_ch_out,
  input  logic [11:0] samp_data_in,
  output logic        eoc_out,
  output logic        eos_out,
  output logic [6:0]  channel_out,
  output logic        err_out
);

  localparam int CNT_W = (EOC_PERIOD > 2) ? $clog2(EOC_PERIOD) : 1;
  localparam int LAT_W = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EOC_PERIOD - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'((RD_LATENCY >= 2) ? RD_LATENCY - 2 : 0);
  localparam logic [3:0]       CH_LAST  = 4'(NUM_CH - 1);
  localparam logic [7:0]       CH_COUNT = 8'(NUM_CH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} drp_state_t;

  drp_state_t       state_reg, state_next;
  logic [LAT_W-1:0] lat_reg, lat_next;
  logic             we_reg;
  logic [6:0]       addr_reg;
  logic [15:0]      di_reg;
  logic             accept, err_set, enter_resp;
  logic             op_we;
  logic [6:0]       op_addr;
  logic [15:0]      op_di;
  logic [7:0]       op_rel;
  logic             op_hit;
  logic [IDX_W-1:0] op_idx;
  logic [CNT_W-1:0] conv_cnt;
  logic             conv_end;
  logic [IDX_W-1:0] samp_idx;
  logic [15:0]      result [NUM_CH];

  always_comb begin
    state_next = state_reg;
    lat_next   = lat_reg;
    accept     = 1'b0;
    err_set    = 1'b0;
    enter_resp = 1'b0;
    case (state_reg)
      S_IDLE, S_RESP: begin
        if (den_in) begin
          accept = 1'b1;
          if (RD_LATENCY == 1) begin
            state_next = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = S_WAIT;
            lat_next   = LAT_LOAD;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        err_set = den_in;
        if (lat_reg == '0) begin
          state_next = S_RESP;
          enter_resp = 1'b1;
        end else begin
          lat_next = lat_reg - 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // With single-cycle latency the operation completes on its acceptance edge,
  // so the live bus is used instead of the latched copy.
  always_comb begin
    op_we   = (state_reg == S_WAIT) ? we_reg   : dwe_in;
    op_addr = (state_reg == S_WAIT) ? addr_reg : daddr_in;
    op_di   = (state_reg == S_WAIT) ? di_reg   : di_in;
    op_rel  = {1'b0, op_addr} - {1'b0, BASE_ADDR};
    op_hit  = (op_addr >= BASE_ADDR) && (op_rel < CH_COUNT);
    op_idx  = op_rel[IDX_W-1:0];
  end

  assign conv_end = (conv_cnt == CNT_LAST);
  assign samp_idx = samp_ch_out[IDX_W-1:0];
  assign drdy_out = (state_reg == S_RESP);

  always_ff @(posedge dclk) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      lat_reg     <= '0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      di_reg      <= '0;
      do_out      <= '0;
      err_out     <= 1'b0;
      conv_cnt    <= '0;
      samp_ch_out <= '0;
      eoc_out     <= 1'b0;
      eos_out     <= 1'b0;
      channel_out <= '0;
      for (int i = 0; i < NUM_CH; i++) result[i] <= '0;
    end else begin
      state_reg <= state_next;
      lat_reg   <= lat_next;
      if (err_set) err_out <= 1'b1;
      if (accept) begin
        we_reg   <= dwe_in;
        addr_reg <= daddr_in;
        di_reg   <= di_in;
      end

      if (conv_end) begin
        conv_cnt          <= '0;
        result[samp_idx]  <= {samp_data_in, 4'h0};
        eoc_out           <= 1'b1;
        eos_out           <= (samp_ch_out == CH_LAST);
        channel_out       <= BASE_ADDR + {3'b000, samp_ch_out};
        samp_ch_out       <= (samp_ch_out == CH_LAST) ? 4'h0 : samp_ch_out + 4'h1;
      end else begin
        conv_cnt <= conv_cnt + 1'b1;
        eoc_out  <= 1'b0;
        eos_out  <= 1'b0;
      end

      // Placed after the capture so a same-edge DRP write overrides it.
      if (enter_resp && op_we && op_hit) result[op_idx] <= op_di;
      if (enter_resp && !op_we) do_out <= op_hit ? result[op_idx] : 16'h0000;
    end
  end

endmodule

// File: tb/tb_drp_adc_responder.sv
// Bench for drp_adc_responder: directed scenarios plus random DRP traffic, every
// cycle compared against a time-indexed behavioural model of the register file.
module tb_drp_adc_responder;

  localparam int N    = 13;
  localparam int E    = 26;
  localparam int L    = 4;
  localparam int BASE = 16;

  logic        dclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        den_in = 1'b0;
  logic        dwe_in = 1'b0;
  logic [6:0]  daddr_in = '0;
  logic [15:0] di_in = '0;
  logic [15:0] do_out;
  logic        drdy_out;
  logic [3:0]  samp_ch_out;
  logic [11:0] samp_data_in = '0;
  logic        eoc_out;
  logic        eos_out;
  logic [6:0]  channel_out;
  logic        err_out;

  drp_adc_responder #(
    .NUM_CH(N), .BASE_ADDR(7'h10), .EOC_PERIOD(E), .RD_LATENCY(L)
  ) dut (
    .dclk(dclk), .rst_n(rst_n), .den_in(den_in), .dwe_in(dwe_in),
    .daddr_in(daddr_in), .di_in(di_in), .do_out(do_out), .drdy_out(drdy_out),
    .samp_ch_out(samp_ch_out), .samp_data_in(samp_data_in), .eoc_out(eoc_out),
    .eos_out(eos_out), .channel_out(channel_out), .err_out(err_out)
  );

  always #5 dclk = ~dclk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: time is counted in cycles since reset release.
  int          m_cyc;
  int          m_resp;
  bit          pend_v;
  int          pend_due;
  logic        pend_we;
  logic [6:0]  pend_addr;
  logic [15:0] pend_di;
  logic [15:0] m_res [16];
  logic [15:0] m_do;
  logic [6:0]  m_chan;
  logic        m_err;
  logic        exp_eoc, exp_eos, exp_drdy;
  int          exp_ch;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, m_cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_resp = -1; pend_v = 0; pend_due = 0;
    pend_we = 0; pend_addr = '0; pend_di = '0;
    for (int i = 0; i < 16; i++) m_res[i] = '0;
    m_do = '0; m_chan = '0; m_err = 0;
    exp_eoc = 0; exp_eos = 0; exp_drdy = 0; exp_ch = 0;
  endtask

  // Predict outputs of cycle m_cyc+1 from the inputs applied during cycle m_cyc.
  task automatic model_edge(input logic den, input logic we, input logic [6:0] addr,
                            input logic [15:0] di, input logic [11:0] samp);
    int c;
    bit cap;
    int ch;
    int a;
    bit inr;
    logic [15:0] pre [16];
    c   = m_cyc;
    cap = (c % E) == E - 1;
    ch  = (c / E) % N;
    pre = m_res;
    if (den) begin
      if (m_resp < 0 || c >= m_resp) begin
        m_resp = c + L; pend_v = 1; pend_due = c + L - 1;
        pend_we = we; pend_addr = addr; pend_di = di;
      end else begin
        m_err = 1;
      end
    end
    if (cap) m_res[ch] = {samp, 4'h0};
    if (pend_v && pend_due == c) begin
      a   = int'(pend_addr);
      inr = (a >= BASE) && (a < BASE + N);
      if (pend_we) begin
        if (inr) m_res[a - BASE] = pend_di;
      end else begin
        m_do = inr ? pre[a - BASE] : 16'h0000;
      end
      pend_v = 0;
    end
    exp_eoc = cap;
    exp_eos = cap && (ch == N - 1);
    if (cap) m_chan = 7'(BASE + ch);
    m_cyc    = c + 1;
    exp_drdy = (m_resp == m_cyc);
    exp_ch   = (m_cyc / E) % N;
  endtask

  task automatic compare_all();
    check("drdy", 32'(drdy_out), 32'(exp_drdy));
    check("do_out", 32'(do_out), 32'(m_do));
    check("eoc", 32'(eoc_out), 32'(exp_eoc));
    check("eos", 32'(eos_out), 32'(exp_eos));
    check("channel", 32'(channel_out), 32'(m_chan));
    check("samp_ch", 32'(samp_ch_out), 32'(exp_ch));
    check("err", 32'(err_out), 32'(m_err));
    if (drdy_out || exp_drdy)
      $display("TXN cycle=%0d drdy=%0b do_out=%h err=%0b", m_cyc, drdy_out, do_out, err_out);
  endtask

  task automatic step(input logic den, input logic we, input logic [6:0] addr,
                      input logic [15:0] di, input logic [11:0] samp);
    den_in = den; dwe_in = we; daddr_in = addr; di_in = di; samp_data_in = samp;
    model_edge(den, we, addr, di, samp);
    @(posedge dclk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input logic [11:0] samp, input bit rnd);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 7'h00, 16'h0000, rnd ? 12'($urandom) : samp);
  endtask

  task automatic do_reset(input int n, input logic den);
    rst_n = 1'b0; den_in = den; dwe_in = 1'b0; daddr_in = 7'h10;
    di_in = '0; samp_data_in = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge dclk);
      #1;
      check("rst_drdy", 32'(drdy_out), 32'd0);
      check("rst_do", 32'(do_out), 32'd0);
      check("rst_eoc", 32'(eoc_out), 32'd0);
      check("rst_eos", 32'(eos_out), 32'd0);
      check("rst_chan", 32'(channel_out), 32'd0);
      check("rst_samp_ch", 32'(samp_ch_out), 32'd0);
      check("rst_err", 32'(err_out), 32'd0);
    end
    model_reset();
    rst_n = 1'b1; den_in = 1'b0;
  endtask

  initial begin
    int tgt;
    model_reset();
    do_reset(3, 1'b1);

    // First conversion and readback of channel 0.
    idle(E, 12'hABC, 1'b0);
    check("first_eoc", 32'(eoc_out), 32'd1);
    check("first_chan", 32'(channel_out), 32'h10);
    step(1'b1, 1'b0, 7'h10, 16'h0, 12'h0);
    idle(L - 1, 12'h0, 1'b0);
    check("rd_ch0_drdy", 32'(drdy_out), 32'd1);
    check("rd_ch0_data", 32'(do_out), 32'hABC0);

    // Write/readback, out-of-range read, out-of-range write.
    step(1'b1, 1'b1, 7'h12, 16'h1234, 12'h0);
    idle(L - 1, 12'h0, 1'b0);
    step(1'b1, 1'b0, 7'h12, 16'h0, 12'h0);
    idle(L - 1, 12'h0, 1'b0);
    check("rd_wr_data", 32'(do_out), 32'h1234);
    step(1'b1, 1'b0, 7'h1D, 16'h0, 12'h0);
    idle(L - 1, 12'h0, 1'b0);
    check("rd_oor_data", 32'(do_out), 32'h0000);
    step(1'b1, 1'b1, 7'h05, 16'hBEEF, 12'h0);
    idle(L - 1, 12'h0, 1'b0);
    check("wr_oor_drdy", 32'(drdy_out), 32'd1);

    // Protocol violation: second strobe while waiting.
    step(1'b1, 1'b0, 7'h11, 16'h0, 12'h0);
    idle(1, 12'h0, 1'b0);
    step(1'b1, 1'b0, 7'h12, 16'h0, 12'h0);
    check("viol_err", 32'(err_out), 32'd1);
    idle(1, 12'h0, 1'b0);
    check("viol_drdy", 32'(drdy_out), 32'd1);
    step(1'b1, 1'b0, 7'h10, 16'h0, 12'h0);
    idle(L - 1, 12'h0, 1'b0);
    check("b2b_drdy", 32'(drdy_out), 32'd1);

    // Full sequence wrap with random samples.
    idle(N * E + 2, 12'h0, 1'b1);

    // Collision: write to channel 3 lands on its capture edge.
    idle(L + 1, 12'hFFF, 1'b0);
    tgt = m_cyc + L;
    while (!(((tgt % E) == E - 1) && (((tgt / E) % N) == 3))) tgt++;
    idle(tgt - (L - 1) - m_cyc, 12'hFFF, 1'b0);
    step(1'b1, 1'b1, 7'h13, 16'h5555, 12'hFFF);
    idle(L, 12'hFFF, 1'b0);
    step(1'b1, 1'b0, 7'h13, 16'h0, 12'h0);
    idle(L - 1, 12'h0, 1'b0);
    check("collision_data", 32'(do_out), 32'h5555);

    // Random DRP traffic, including strobes during busy periods.
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 2) == 0)
        step(1'b1, 1'($urandom), ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'($urandom_range(12, 33)),
             16'($urandom), 12'($urandom));
      else
        idle(1, 12'h0, 1'b1);
    end

    // Reset in the middle of a transaction: no response may follow.
    idle(L + 1, 12'h0, 1'b1);
    step(1'b1, 1'b0, 7'h10, 16'h0, 12'h0);
    idle(1, 12'h0, 1'b0);
    do_reset(2, 1'b0);
    idle(L + 2, 12'h0, 1'b1);
    check("post_rst_err", 32'(err_out), 32'd0);
    idle(E, 12'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
